// File: rtl/ili9341_frame_streamer.sv
// ili9341_frame_streamer
// Generates full frames of RGB565 test-pattern pixels for an ILI9341 SPI
// pixel sink. Frames are raster-ordered (x fastest), one pixel per accepted
// handshake, with a two-cycle idle gap (DONE + IDLE) between frames.
//
// Handshake: pix_valid/pix_ready follow strict valid/ready rules. pix_valid is
// high for every STREAM cycle and does not depend on pix_ready. A pixel
// transfers on a rising edge where both are high. While valid and not ready,
// pix_data and the pixel position are held.
//
// dbg_state_o exposes the FSM state: 0 = IDLE, 1 = STREAM, 2 = DONE.
module ili9341_frame_streamer #(
    parameter int H_PIXELS  = 10,
    parameter int V_PIXELS  = 10,
    parameter int CELL_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [2:0]  visua,
    input  logic [1:0]  mode,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic [7:0]  frame_cnt,
    output logic [1:0]  dbg_state_o
);

    localparam int XW = ($clog2(H_PIXELS) > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW = ($clog2(V_PIXELS) > 1) ? $clog2(V_PIXELS) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [2:0]      visua_q, visua_d;
    logic [1:0]      mode_q, mode_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;

    // Pattern helpers
    logic [15:0]     colour;
    logic [XW-1:0]   x_cell;
    logic [YW-1:0]   y_cell;
    logic            x_cell_odd;
    logic            y_cell_odd;
    logic            on_border;
    logic [15:0]     pattern;

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            visua_q       <= '0;
            mode_q        <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            visua_q       <= visua_d;
            mode_q        <= mode_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Next-state logic: frame launch, raster advance on accept, frame wrap-up.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        visua_d       = visua_q;
        mode_d        = mode_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    // Pattern selects are frozen here for the whole frame.
                    state_d       = S_STREAM;
                    visua_d       = visua;
                    mode_d        = mode;
                    x_d           = '0;
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end
            end
            S_STREAM: begin
                if (pix_ready) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            // Last pixel accepted; enable is ignored mid-frame.
                            y_d          = '0;
                            state_d      = S_DONE;
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 8'd1;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel colour from latched selects and current raster position.
    always_comb begin
        case (visua_q)
            3'd0:    colour = 16'hFFE0;
            3'd1:    colour = 16'h07FF;
            3'd2:    colour = 16'hF800;
            3'd3:    colour = 16'h780F;
            3'd4:    colour = 16'h0000;
            default: colour = 16'h001F;
        endcase
        x_cell     = x_q >> CELL_LOG2;
        y_cell     = y_q >> CELL_LOG2;
        x_cell_odd = |(x_cell & XW'(1));
        y_cell_odd = |(y_cell & YW'(1));
        on_border  = (x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST);
        case (mode_q)
            2'd0:    pattern = colour;
            2'd1:    pattern = y_cell_odd ? ~colour : colour;
            2'd2:    pattern = (x_cell_odd ^ y_cell_odd) ? ~colour : colour;
            default: pattern = on_border ? colour : 16'h0000;
        endcase
    end

    assign pix_valid   = (state_q == S_STREAM);
    assign pix_data    = pix_valid ? pattern : 16'h0000;
    assign busy        = (state_q == S_STREAM) || (state_q == S_DONE);
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ili9341_frame_streamer.sv
// Directed testbench for ili9341_frame_streamer. Two instances: a small 4x2
// frame for timing/counter scenarios and a 16x16 frame for pattern content.
module tb_ili9341_frame_streamer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: 4x2
  logic        a_rst, a_enable, a_ready;
  logic [2:0]  a_visua;
  logic [1:0]  a_mode;
  logic        a_valid, a_fs, a_fd, a_busy;
  logic [15:0] a_data;
  logic [7:0]  a_cnt;
  logic [1:0]  a_state;

  // DUT b: 16x16
  logic        b_rst, b_enable, b_ready;
  logic [2:0]  b_visua;
  logic [1:0]  b_mode;
  logic        b_valid, b_fs, b_fd, b_busy;
  logic [15:0] b_data;
  logic [7:0]  b_cnt;
  logic [1:0]  b_state;

  ili9341_frame_streamer #(.H_PIXELS(4), .V_PIXELS(2), .CELL_LOG2(3)) dut_a (
    .clk(clk), .rst(a_rst), .enable(a_enable), .visua(a_visua), .mode(a_mode),
    .pix_ready(a_ready), .pix_valid(a_valid), .pix_data(a_data),
    .frame_start(a_fs), .frame_done(a_fd), .busy(a_busy),
    .frame_cnt(a_cnt), .dbg_state_o(a_state)
  );

  ili9341_frame_streamer #(.H_PIXELS(16), .V_PIXELS(16), .CELL_LOG2(3)) dut_b (
    .clk(clk), .rst(b_rst), .enable(b_enable), .visua(b_visua), .mode(b_mode),
    .pix_ready(b_ready), .pix_valid(b_valid), .pix_data(b_data),
    .frame_start(b_fs), .frame_done(b_fd), .busy(b_busy),
    .frame_cnt(b_cnt), .dbg_state_o(b_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cap[256];
  int          b_frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Independent reference pattern.
  function automatic logic [15:0] model(input int h, input int v, input int cl,
                                        input logic [2:0] vis, input logic [1:0] md,
                                        input int x, input int y);
    logic [15:0] c;
    case (vis)
      3'd0: c = 16'hFFE0;
      3'd1: c = 16'h07FF;
      3'd2: c = 16'hF800;
      3'd3: c = 16'h780F;
      3'd4: c = 16'h0000;
      default: c = 16'h001F;
    endcase
    case (md)
      2'd0: return c;
      2'd1: return (((y >> cl) & 1) != 0) ? ~c : c;
      2'd2: return ((((x >> cl) ^ (y >> cl)) & 1) != 0) ? ~c : c;
      default: return (x == 0 || x == h - 1 || y == 0 || y == v - 1) ? c : 16'h0000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams one 16x16 frame on DUT b; selects change at accept 100.
  task automatic run_b_frame(input logic [2:0] vis, input logic [1:0] md, input bit stall,
                             input logic [2:0] vis_mid, input logic [1:0] md_mid);
    logic [3:0]  pat;
    logic [15:0] hold, e;
    int          accepts;
    int          cyc;
    pat = 4'b1001;
    exp_q = {};
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        exp_q.push_back(model(16, 16, 3, vis, md, x, y));
    b_visua  = vis;
    b_mode   = md;
    b_enable = 1'b1;
    b_ready  = 1'b1;
    step();
    b_enable = 1'b0;
    chk("b_frame_start", {31'd0, b_fs}, 32'd1);
    accepts = 0;
    cyc = 0;
    while (accepts < 256 && cyc < 2000) begin
      b_ready = stall ? pat[cyc % 4] : 1'b1;
      if (accepts == 100) begin
        b_visua = vis_mid;
        b_mode  = md_mid;
      end
      chk("b_valid_stream", {31'd0, b_valid}, 32'd1);
      chk("b_done_low", {31'd0, b_fd}, 32'd0);
      if (cyc > 0) chk("b_start_low", {31'd0, b_fs}, 32'd0);
      if (b_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        chk("b_pixel", {16'd0, b_data}, {16'd0, e});
        cap[accepts] = b_data;
        accepts++;
        step();
      end else begin
        hold = b_data;
        step();
        chk("b_stall_hold", {16'd0, b_data}, {16'd0, hold});
      end
      cyc++;
    end
    b_frames++;
    chk("b_accept_count", accepts, 256);
    chk("b_frame_done", {31'd0, b_fd}, 32'd1);
    chk("b_valid_done", {31'd0, b_valid}, 32'd0);
    chk("b_data_done", {16'd0, b_data}, 32'd0);
    chk("b_frame_cnt", {24'd0, b_cnt}, {24'd0, 8'(b_frames)});
    step();
    chk("b_busy_idle", {31'd0, b_busy}, 32'd0);
    chk("b_done_pulse_end", {31'd0, b_fd}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    a_rst = 1'b1; a_enable = 1'b0; a_ready = 1'b0; a_visua = 3'd0; a_mode = 2'd0;
    b_rst = 1'b1; b_enable = 1'b0; b_ready = 1'b0; b_visua = 3'd0; b_mode = 2'd0;
    step();
    step();
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Reset state
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_data", {16'd0, a_data}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_cnt", {24'd0, a_cnt}, 32'd0);
    chk("rst_fs", {31'd0, a_fs}, 32'd0);
    chk("rst_fd", {31'd0, a_fd}, 32'd0);
    chk("rst_state_a", {30'd0, a_state}, 32'd0);
    chk("rst_state_b", {30'd0, b_state}, 32'd0);
    step();
    chk("idle_no_enable", {31'd0, a_valid}, 32'd0);

    // 4x2 solid F800, enable pulsed one cycle, ready high
    a_enable = 1'b1; a_visua = 3'd2; a_mode = 2'd0; a_ready = 1'b1;
    step();
    a_enable = 1'b0;
    a_visua  = 3'd5;
    chk("a_fs_pulse", {31'd0, a_fs}, 32'd1);
    chk("a_busy_stream", {31'd0, a_busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("a_valid_px", {31'd0, a_valid}, 32'd1);
      chk("a_solid_px", {16'd0, a_data}, 32'h0000_F800);
      chk("a_fd_low", {31'd0, a_fd}, 32'd0);
      if (i > 0) chk("a_fs_low", {31'd0, a_fs}, 32'd0);
      step();
    end
    chk("a_fd_pulse", {31'd0, a_fd}, 32'd1);
    chk("a_valid_done", {31'd0, a_valid}, 32'd0);
    chk("a_data_done", {16'd0, a_data}, 32'd0);
    chk("a_cnt_one", {24'd0, a_cnt}, 32'd1);
    chk("a_busy_done", {31'd0, a_busy}, 32'd1);
    step();
    chk("a_fd_once", {31'd0, a_fd}, 32'd0);
    chk("a_busy_idle", {31'd0, a_busy}, 32'd0);
    step();
    chk("a_stays_idle", {31'd0, a_valid}, 32'd0);

    // 16x16 checker with stalling ready 1,0,0,1
    run_b_frame(3'd0, 2'd2, 1'b1, 3'd0, 2'd2);
    chk("chk_px_0_0", {16'd0, cap[0]}, 32'h0000_FFE0);
    chk("chk_px_8_0", {16'd0, cap[8]}, 32'h0000_001F);
    chk("chk_px_8_8", {16'd0, cap[8 * 16 + 8]}, 32'h0000_FFE0);
    chk("chk_px_0_8", {16'd0, cap[8 * 16]}, 32'h0000_001F);

    // Border, visua changed 1 -> 3 mid-frame; then next frame with 3
    run_b_frame(3'd1, 2'd3, 1'b0, 3'd3, 2'd0);
    chk("brd_corner", {16'd0, cap[0]}, 32'h0000_07FF);
    chk("brd_right", {16'd0, cap[7 * 16 + 15]}, 32'h0000_07FF);
    chk("brd_interior", {16'd0, cap[1 * 16 + 1]}, 32'h0000_0000);
    chk("brd_bottom", {16'd0, cap[255]}, 32'h0000_07FF);
    run_b_frame(3'd3, 2'd3, 1'b0, 3'd3, 2'd3);
    chk("brd2_corner", {16'd0, cap[0]}, 32'h0000_780F);

    // Bars and solid variants, with stalls
    run_b_frame(3'd5, 2'd1, 1'b1, 3'd0, 2'd0);
    chk("bars_row0", {16'd0, cap[0]}, 32'h0000_001F);
    chk("bars_row8", {16'd0, cap[8 * 16 + 3]}, 32'h0000_FFE0);
    run_b_frame(3'd6, 2'd0, 1'b0, 3'd2, 2'd1);
    chk("solid_v6", {16'd0, cap[200]}, 32'h0000_001F);

    // Reset mid-frame at pixel 5 of 8
    a_enable = 1'b1; a_visua = 3'd4; a_mode = 2'd0; a_ready = 1'b1;
    step();
    a_enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rst_mid_valid_before", {31'd0, a_valid}, 32'd1);
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    chk("rst_mid_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_mid_fd", {31'd0, a_fd}, 32'd0);
    chk("rst_mid_cnt", {24'd0, a_cnt}, 32'd0);
    step();
    chk("rst_mid_fd_after", {31'd0, a_fd}, 32'd0);
    chk("rst_mid_cnt_after", {24'd0, a_cnt}, 32'd0);
    // Next frame must be a full 8 pixels from (0,0)
    a_enable = 1'b1;
    step();
    a_enable = 1'b0;
    acc = 0;
    for (int c = 0; c < 50 && !a_fd; c++) begin
      if (a_valid && a_ready) acc++;
      step();
    end
    chk("restart_accepts", acc, 8);
    chk("restart_fd", {31'd0, a_fd}, 32'd1);
    chk("restart_cnt", {24'd0, a_cnt}, 32'd1);
    step();

    // 256 back-to-back frames, enable held high
    a_enable = 1'b1; a_visua = 3'd1; a_mode = 2'd2; a_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      step();
      chk("bb_fs", {31'd0, a_fs}, 32'd1);
      chk("bb_valid_first", {31'd0, a_valid}, 32'd1);
      for (int k = 1; k < 8; k++) begin
        step();
        chk("bb_valid", {31'd0, a_valid}, 32'd1);
        chk("bb_fs_low", {31'd0, a_fs}, 32'd0);
      end
      step();
      chk("bb_fd", {31'd0, a_fd}, 32'd1);
      chk("bb_gap1", {31'd0, a_valid}, 32'd0);
      chk("bb_cnt", {24'd0, a_cnt}, {24'd0, 8'(f + 2)});
      if (f == 254) chk("bb_cnt_wrap", {24'd0, a_cnt}, 32'd0);
      if (f == 255) a_enable = 1'b0;
      step();
      chk("bb_gap2", {31'd0, a_valid}, 32'd0);
      chk("bb_fd_low", {31'd0, a_fd}, 32'd0);
      chk("bb_fs_gap", {31'd0, a_fs}, 32'd0);
    end
    step();
    chk("bb_end_idle", {31'd0, a_valid}, 32'd0);
    chk("bb_end_busy", {31'd0, a_busy}, 32'd0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ili9341_frame_streamer.md
ILI9341_FRAME_STREAMER -- requirements
Module: ili9341_frame_streamer

Interface
REQ-001 The block SHALL have parameter H_PIXELS, default 10, meaning pixels per line (>=2).
REQ-002 The block SHALL have parameter V_PIXELS, default 10, meaning lines per frame (>=2).
REQ-003 The block SHALL have parameter CELL_LOG2, default 3, meaning log2 of pattern cell size in pixels.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-006 The block SHALL have port enable, input, 1, meaning stream frames continuously while high.
REQ-007 The block SHALL have port visua, input, 3, meaning image/colour select.
REQ-008 The block SHALL have port mode, input, 2, meaning pattern select: 0 solid, 1 bars, 2 checker, 3 border.
REQ-009 The block SHALL have port pix_ready, input, 1, meaning the downstream SPI controller accepts a pixel.
REQ-010 The block SHALL have port pix_valid, output, 1, meaning pix_data holds a valid pixel.
REQ-011 The block SHALL have port pix_data, output, 16, meaning an RGB565 pixel.
REQ-012 The block SHALL have port frame_start, output, 1, meaning a one-cycle pulse when a frame begins streaming.
REQ-013 The block SHALL have port frame_done, output, 1, meaning a one-cycle pulse after the last pixel is accepted.
REQ-014 The block SHALL have port busy, output, 1, meaning high in STREAM and DONE.
REQ-015 The block SHALL have port frame_cnt, output, 8, meaning completed frames, modulo 256.

Function
REQ-016 The FSM SHALL have states IDLE, STREAM and DONE.
REQ-017 In IDLE with enable=1, the next cycle SHALL enter STREAM, latch visua and mode, set x=y=0, and pulse frame_start.
REQ-018 In IDLE with enable=0, the FSM SHALL remain in IDLE with pix_valid=0.
REQ-019 In STREAM, pix_valid SHALL be 1, and a pixel SHALL be accepted only on a cycle with pix_valid=1 and pix_ready=1.
REQ-020 On accept, x SHALL increment; at x=H_PIXELS-1, x SHALL wrap to 0 and y SHALL increment.
REQ-021 On accept of pixel (H_PIXELS-1, V_PIXELS-1), the next state SHALL be DONE, frame_done SHALL pulse, and frame_cnt SHALL increment, wrapping 255->0.
REQ-022 In DONE, pix_valid SHALL be 0 for exactly one cycle, then the FSM SHALL go to IDLE, which re-evaluates enable; frames are therefore separated by a gap of at least 2 cycles.
REQ-023 While pix_valid=1 and pix_ready=0, pix_data, x and y SHALL hold unchanged.
REQ-024 Changes on visua or mode after the latch SHALL NOT affect the current frame.
REQ-025 Deasserting enable mid-frame SHALL NOT abort the frame.
REQ-026 The colour palette on the latched visua SHALL be: 0=FFE0, 1=07FF, 2=F800, 3=780F, 4=0000, 5..7=001F.
REQ-027 Let C be the palette colour and ~C its bitwise inverse; the pixel value SHALL be:
- mode 0 (solid): C.
- mode 1 (bars): C if bit0 of (y>>CELL_LOG2)=0, else ~C.
- mode 2 (checker): C if bit0 of ((x>>CELL_LOG2) XOR (y>>CELL_LOG2))=0, else ~C.
- mode 3 (border): C if x=0, x=H_PIXELS-1, y=0 or y=V_PIXELS-1, else 0000.
REQ-028 pix_data SHALL be 0000 whenever pix_valid=0.
REQ-029 The x and y counters SHALL be $clog2(H_PIXELS) and $clog2(V_PIXELS) bits wide, minimum 1 bit each.
REQ-030 If pix_ready is held high, latency SHALL be 1 pixel per cycle, so STREAM lasts H_PIXELS*V_PIXELS cycles.

Reset
REQ-031 rst=1 SHALL force, on the next clock edge: state=IDLE, x=y=0, pix_valid=0, pix_data=0000, frame_start=0, frame_done=0, busy=0, frame_cnt=0, and latched visua/mode=0.
REQ-032 rst takes priority over all inputs; reset mid-frame SHALL abort the frame with no frame_done pulse and no frame_cnt change.

Verification
REQ-033 H=4, V=2, mode=0, visua=2, pix_ready=1, enable pulsed 1 cycle -> 8 consecutive pixels of F800, frame_done on the cycle after the 8th accept, frame_cnt=1, then IDLE.
REQ-034 H=V=16, CELL_LOG2=3, mode=2, visua=0 -> pixel(0,0)=FFE0, pixel(8,0)=001F, pixel(8,8)=FFE0.
REQ-035 pix_ready toggled 1,0,0,1 during STREAM -> pix_data/x/y hold across the stall cycles; no pixel is lost or duplicated; total accepts = H*V.
REQ-036 visua changed from 1 to 3 mid-frame with mode=3 -> all border pixels of the frame are 07FF and the interior is 0000; the next frame uses 780F.
REQ-037 rst asserted at pixel 5 of 8 -> pix_valid=0 next cycle, frame_done never pulses, frame_cnt stays 0; the next frame restarts at (0,0).
REQ-038 enable held high for 256 frames -> frame_cnt wraps to 0, the inter-frame gap is 2 cycles, and a frame_start pulse occurs at each frame.
